// File: rtl/arm_shift_pkg.sv
// Shared types for the ARM shifter-operand stage: shift encodings, FSM states,
// the latched request record and a rotate helper.
package arm_shift_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_CALC  = 2'b01,
    ST_FULL  = 2'b10
  } state_e;

  typedef struct packed {
    logic             immMode;
    logic [7:0]       imm8;
    logic [3:0]       rot4;
    logic [WIDTH-1:0] rm;
    shift_e           shiftType;
    logic             regShift;
    logic [4:0]       shamt;
    logic [7:0]       rsAmt;
    logic             cIn;
  } req_t;

  // A rotate by zero must return the value untouched; the left half of the
  // OR vanishes because a 32-bit value shifted by 32 is zero.
  function automatic logic [WIDTH-1:0] rorW(input logic [WIDTH-1:0] v,
                                            input logic [4:0]       n);
    return (v >> n) | (v << (6'd32 - {1'b0, n}));
  endfunction

endpackage

// File: rtl/arm_shifter_stage_if.sv
// Request/response bundle between the decode side (master) and the shifter stage (slave).
interface arm_shifter_stage_if;
  import arm_shift_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic             imm_mode;
  logic [7:0]       imm8;
  logic [3:0]       rot4;
  logic [WIDTH-1:0] rm;
  logic [1:0]       shift_type;
  logic             reg_shift;
  logic [4:0]       shamt;
  logic [31:0]      rs;
  logic             c_in;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] b_out;
  logic             c_out;

  modport master (
    output in_valid, imm_mode, imm8, rot4, rm, shift_type, reg_shift,
           shamt, rs, c_in, flush, out_ready,
    input  in_ready, out_valid, b_out, c_out
  );

  modport slave (
    input  in_valid, imm_mode, imm8, rot4, rm, shift_type, reg_shift,
           shamt, rs, c_in, flush, out_ready,
    output in_ready, out_valid, b_out, c_out
  );

endinterface

// File: rtl/arm_barrel_core.sv
// Purely combinational ARM operand-2 barrel shifter: {b, carry} from one request record.
module arm_barrel_core
  import arm_shift_pkg::*;
(
  input  req_t             req_i,
  output logic [WIDTH-1:0] b_o,
  output logic             c_o
);

  logic [4:0]       amt;
  logic [7:0]       regAmt;
  logic [WIDTH:0]   lslExt;
  logic [WIDTH:0]   lsrExt;
  logic [WIDTH:0]   asrExt;
  logic [WIDTH-1:0] sign;
  logic [WIDTH-1:0] rorRm;
  logic [WIDTH-1:0] immRot;

  // The extra bit on each shifted copy is the last bit shifted out, i.e. the carry.
  always_comb begin
    regAmt = req_i.rsAmt;
    amt    = req_i.regShift ? regAmt[4:0] : req_i.shamt;
    lslExt = {1'b0, req_i.rm} << amt;
    lsrExt = {req_i.rm, 1'b0} >> amt;
    asrExt = $signed({req_i.rm, 1'b0}) >>> amt;
    sign   = {WIDTH{req_i.rm[WIDTH-1]}};
    rorRm  = rorW(req_i.rm, amt);
    immRot = rorW({24'h0, req_i.imm8}, {req_i.rot4, 1'b0});

    b_o = req_i.rm;
    c_o = req_i.cIn;

    if (req_i.immMode) begin
      b_o = immRot;
      c_o = (req_i.rot4 == 4'd0) ? req_i.cIn : immRot[WIDTH-1];
    end else if (!req_i.regShift) begin
      unique case (req_i.shiftType)
        SH_LSL: if (amt != 5'd0) {c_o, b_o} = lslExt;
        SH_LSR: begin
          if (amt == 5'd0) begin
            b_o = '0;
            c_o = req_i.rm[WIDTH-1];
          end else begin
            b_o = lsrExt[WIDTH:1];
            c_o = lsrExt[0];
          end
        end
        SH_ASR: begin
          if (amt == 5'd0) begin
            b_o = sign;
            c_o = req_i.rm[WIDTH-1];
          end else begin
            b_o = asrExt[WIDTH:1];
            c_o = asrExt[0];
          end
        end
        SH_ROR: begin
          if (amt == 5'd0) begin
            b_o = {req_i.cIn, req_i.rm[WIDTH-1:1]};
            c_o = req_i.rm[0];
          end else begin
            b_o = rorRm;
            c_o = rorRm[WIDTH-1];
          end
        end
      endcase
    end else if (regAmt != 8'd0) begin
      // Register amounts saturate: 32 leaves one meaningful carry bit, beyond that nothing.
      unique case (req_i.shiftType)
        SH_LSL: begin
          if (regAmt < 8'd32) begin
            {c_o, b_o} = lslExt;
          end else begin
            b_o = '0;
            c_o = (regAmt == 8'd32) ? req_i.rm[0] : 1'b0;
          end
        end
        SH_LSR: begin
          if (regAmt < 8'd32) begin
            b_o = lsrExt[WIDTH:1];
            c_o = lsrExt[0];
          end else begin
            b_o = '0;
            c_o = (regAmt == 8'd32) ? req_i.rm[WIDTH-1] : 1'b0;
          end
        end
        SH_ASR: begin
          if (regAmt < 8'd32) begin
            b_o = asrExt[WIDTH:1];
            c_o = asrExt[0];
          end else begin
            b_o = sign;
            c_o = req_i.rm[WIDTH-1];
          end
        end
        SH_ROR: begin
          b_o = rorRm;
          c_o = rorRm[WIDTH-1];
        end
      endcase
    end
  end

endmodule

// File: rtl/arm_shifter_stage.sv
// Pipeline stage in front of the ALU: latches an operand request, runs it through the
// barrel core (one extra cycle for register-specified amounts) and holds the result.
module arm_shifter_stage
  import arm_shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  arm_shifter_stage_if.slave   bus
);

  state_e           state_q, state_d;
  req_t             req_q, req_d;
  req_t             inReq;
  req_t             coreReq;
  logic [WIDTH-1:0] bOut_q, bOut_d;
  logic             cOut_q, cOut_d;
  logic [WIDTH-1:0] coreB;
  logic             coreC;
  logic             accept;
  logic             load;

  always_comb begin
    inReq           = '0;
    inReq.immMode   = bus.imm_mode;
    inReq.imm8      = bus.imm8;
    inReq.rot4      = bus.rot4;
    inReq.rm        = bus.rm;
    inReq.shiftType = shift_e'(bus.shift_type);
    inReq.regShift  = bus.reg_shift;
    inReq.shamt     = bus.shamt;
    inReq.rsAmt     = bus.rs[7:0];
    inReq.cIn       = bus.c_in;
  end

  assign bus.in_ready  = (state_q == ST_EMPTY) || ((state_q == ST_FULL) && bus.out_ready);
  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.b_out     = bOut_q;
  assign bus.c_out     = cOut_q;
  assign accept        = bus.in_valid && bus.in_ready && !bus.flush;

  // Single-cycle ops are shifted straight off the inputs; CALC replays the latched copy.
  assign coreReq = (state_q == ST_CALC) ? req_q : inReq;

  arm_barrel_core uCore (
    .req_i (coreReq),
    .b_o   (coreB),
    .c_o   (coreC)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    load    = 1'b0;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: state_d = ST_EMPTY;
        ST_CALC: begin
          state_d = ST_FULL;
          load    = 1'b1;
        end
        ST_FULL:  if (bus.out_ready) state_d = ST_EMPTY;
        default:  state_d = ST_EMPTY;
      endcase
      if (accept) begin
        req_d   = inReq;
        state_d = inReq.regShift ? ST_CALC : ST_FULL;
        load    = !inReq.regShift;
      end
    end
    bOut_d = load ? coreB : bOut_q;
    cOut_d = load ? coreC : cOut_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      req_q   <= '0;
      bOut_q  <= '0;
      cOut_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      bOut_q  <= bOut_d;
      cOut_q  <= cOut_d;
    end
  end

endmodule

// File: tb/tb_arm_shifter_stage.sv
// Scoreboard bench for arm_shifter_stage: directed corner cases followed by random requests
// checked against a bit-serial shift model.
module tb_arm_shifter_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arm_shifter_stage_if bus();

  arm_shifter_stage #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        immMode;
    logic [7:0]  imm8;
    logic [3:0]  rot4;
    logic [31:0] rm;
    logic [1:0]  st;
    logic        regShift;
    logic [4:0]  shamt;
    logic [31:0] rs;
    logic        cIn;
  } stim_t;

  int          assertCount = 0;
  int          failCount   = 0;
  logic [32:0] expQ[$];
  bit          randomReady = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  // Shift one bit position at a time; the carry is whatever bit fell off last.
  function automatic logic [32:0] refModel(input stim_t s);
    logic [31:0] v;
    logic        c;
    int          n;
    if (s.immMode) begin
      v = {24'h0, s.imm8};
      for (int i = 0; i < 2 * int'(s.rot4); i++) v = {v[0], v[31:1]};
      c = (s.rot4 == 4'd0) ? s.cIn : v[31];
      return {v, c};
    end
    if (s.regShift) begin
      n = int'(s.rs[7:0]);
    end else begin
      n = int'(s.shamt);
      if (n == 0 && s.st == 2'b11) return {s.cIn, s.rm[31:1], s.rm[0]};
      if (n == 0 && (s.st == 2'b01 || s.st == 2'b10)) n = 32;
    end
    v = s.rm;
    c = s.cIn;
    for (int i = 0; i < n; i++) begin
      case (s.st)
        2'b00:   begin c = v[31]; v = v << 1;               end
        2'b01:   begin c = v[0];  v = v >> 1;               end
        2'b10:   begin c = v[0];  v = {v[31], v[31:1]};     end
        default: begin c = v[0];  v = {v[0], v[31:1]};      end
      endcase
    end
    return {v, c};
  endfunction

  function automatic stim_t mkImm(input logic [7:0] imm8, input logic [3:0] rot4, input logic cIn);
    stim_t s;
    s = '{immMode: 1'b1, imm8: imm8, rot4: rot4, rm: 32'hDEAD_BEEF, st: 2'b00,
          regShift: 1'b0, shamt: 5'd0, rs: 32'h0, cIn: cIn};
    return s;
  endfunction

  function automatic stim_t mkShift(input logic [31:0] rm, input logic [1:0] st, input logic regShift,
                                    input logic [4:0] shamt, input logic [31:0] rs, input logic cIn);
    stim_t s;
    s = '{immMode: 1'b0, imm8: 8'h0, rot4: 4'h0, rm: rm, st: st,
          regShift: regShift, shamt: shamt, rs: rs, cIn: cIn};
    return s;
  endfunction

  task automatic cycleStart();
    @(posedge clk);
    #1;
  endtask

  // Drive a request from posedge+1; returns at posedge+1 after the accepting edge.
  task automatic applyStimulus(input stim_t s, input bit expectResult);
    bit accepted = 1'b0;
    bus.imm_mode   = s.immMode;
    bus.imm8       = s.imm8;
    bus.rot4       = s.rot4;
    bus.rm         = s.rm;
    bus.shift_type = s.st;
    bus.reg_shift  = s.regShift;
    bus.shamt      = s.shamt;
    bus.rs         = s.rs;
    bus.c_in       = s.cIn;
    bus.in_valid   = 1'b1;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      if (bus.in_ready && !bus.flush) begin
        accepted = 1'b1;
        if (expectResult) expQ.push_back(refModel(s));
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!accepted) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL acceptTimeout: in_ready stayed 0, required 1 within 50 cycles");
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (expQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unexpectedResult: got b_out=0x%08h c_out=%0b, required no output",
                 bus.b_out, bus.c_out);
      end else begin
        checkOutput("scoreboard", {31'b0, bus.b_out, bus.c_out}, {31'b0, expQ.pop_front()});
      end
    end
  end

  always @(posedge clk) begin
    if (randomReady) begin
      #1;
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;
    logic [32:0] e;
    logic [7:0]  amt;
    bus.in_valid = 1'b0; bus.imm_mode = 1'b0; bus.imm8 = '0; bus.rot4 = '0;
    bus.rm = '0; bus.shift_type = '0; bus.reg_shift = 1'b0; bus.shamt = '0;
    bus.rs = '0; bus.c_in = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("resetOutValid", 64'(bus.out_valid), 64'd0);
    checkOutput("resetBOut", 64'(bus.b_out), 64'd0);
    checkOutput("resetCOut", 64'(bus.c_out), 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("resetInReady", 64'(bus.in_ready), 64'd1);
    cycleStart();

    $display("[TB] immediate rotate");
    bus.out_ready = 1'b1;
    applyStimulus(mkImm(8'hFF, 4'd4, 1'b0), 1'b1);
    @(negedge clk);
    checkOutput("immValid", 64'(bus.out_valid), 64'd1);
    checkOutput("immResult", {31'b0, bus.b_out, bus.c_out}, {31'b0, 32'hFF00_0000, 1'b1});

    $display("[TB] LSR #0 and RRX back to back");
    cycleStart();
    applyStimulus(mkShift(32'h8000_0001, 2'b01, 1'b0, 5'd0, 32'h0, 1'b0), 1'b1);
    @(negedge clk);
    checkOutput("lsr0", {31'b0, bus.out_valid, bus.b_out, bus.c_out}, {31'b0, 1'b1, 32'h0, 1'b1});
    cycleStart();
    applyStimulus(mkShift(32'h0000_0003, 2'b11, 1'b0, 5'd0, 32'h0, 1'b1), 1'b1);
    @(negedge clk);
    checkOutput("rrx", {31'b0, bus.out_valid, bus.b_out, bus.c_out}, {31'b0, 1'b1, 32'h8000_0001, 1'b1});

    $display("[TB] register shift latency");
    cycleStart();
    applyStimulus(mkShift(32'hFFFF_FFFF, 2'b00, 1'b1, 5'd0, 32'h21, 1'b1), 1'b1);
    bus.rm = 32'h1234_5678;
    bus.rs = 32'h0;
    @(negedge clk);
    checkOutput("calcInReady", 64'(bus.in_ready), 64'd0);
    checkOutput("calcOutValid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    checkOutput("regLsl33", {31'b0, bus.out_valid, bus.b_out, bus.c_out}, {31'b0, 1'b1, 32'h0, 1'b0});

    $display("[TB] backpressure then back-to-back");
    cycleStart();
    bus.out_ready = 1'b0;
    s = mkImm(8'h5A, 4'd1, 1'b0);
    e = refModel(s);
    applyStimulus(s, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("holdResult", {30'b0, bus.out_valid, bus.b_out, bus.c_out}, {30'b0, 1'b1, e});
      checkOutput("holdInReady", 64'(bus.in_ready), 64'd0);
    end
    cycleStart();
    bus.out_ready = 1'b1;
    s = mkImm(8'hC3, 4'd15, 1'b1);
    e = refModel(s);
    applyStimulus(s, 1'b1);
    @(negedge clk);
    checkOutput("noBubble", {30'b0, bus.out_valid, bus.b_out, bus.c_out}, {30'b0, 1'b1, e});

    $display("[TB] flush during CALC");
    cycleStart();
    applyStimulus(mkShift(32'hF0F0_F0F0, 2'b10, 1'b1, 5'd0, 32'h4, 1'b0), 1'b0);
    bus.flush = 1'b1;
    @(negedge clk);
    checkOutput("flushCalcInReady", 64'(bus.in_ready), 64'd0);
    cycleStart();
    bus.flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("flushNoValid", {62'b0, bus.out_valid, bus.in_ready}, {62'b0, 1'b0, 1'b1});
    end

    $display("[TB] asynchronous reset while FULL");
    cycleStart();
    bus.out_ready = 1'b0;
    applyStimulus(mkImm(8'h81, 4'd4, 1'b0), 1'b1);
    @(negedge clk);
    checkOutput("preResetResult", {31'b0, bus.out_valid, bus.b_out, bus.c_out}, {31'b0, 1'b1, 32'h8100_0000, 1'b1});
    #2 rst_n = 1'b0;
    #1;
    checkOutput("asyncReset", {31'b0, bus.out_valid, bus.b_out, bus.c_out}, 64'd0);
    expQ.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("postResetInReady", {62'b0, bus.in_ready, bus.out_valid}, {62'b0, 1'b1, 1'b0});

    $display("[TB] random requests");
    cycleStart();
    randomReady = 1'b1;
    for (int n = 0; n < 400; n++) begin
      s.immMode  = ($urandom_range(0, 3) == 0);
      s.imm8     = 8'($urandom);
      s.rot4     = 4'($urandom);
      s.rm       = $urandom;
      s.st       = 2'($urandom);
      s.regShift = ($urandom_range(0, 2) == 0);
      s.shamt    = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
      case ($urandom_range(0, 5))
        0:       amt = 8'd0;
        1:       amt = 8'd32;
        2:       amt = 8'($urandom_range(33, 255));
        3:       amt = 8'(32 * $urandom_range(2, 7));
        default: amt = 8'($urandom_range(1, 31));
      endcase
      s.rs  = {24'($urandom), amt};
      s.cIn = 1'($urandom);
      if ($urandom_range(0, 4) == 0) cycleStart();
      applyStimulus(s, 1'b1);
    end
    for (int i = 0; i < 300 && expQ.size() != 0; i++) @(negedge clk);
    checkOutput("drain", 64'(expQ.size()), 64'd0);
    randomReady = 1'b0;

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
